// File: rtl/pe_conv_sched_pkg.sv
// pe_conv_sched_pkg: shared scheduler state encoding and parameter defaults
package pe_conv_sched_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int K_DEF = 5;
   localparam int PE_LAT_DEF = 2;
endpackage

// File: rtl/pe_conv_sched_pipe.sv
// pe_lat_pipe: LAT-deep shift line carrying window valid and its output address
module pe_lat_pipe #(
   parameter int LAT = 2,
   parameter int AW  = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          v_in,
   input  logic [AW-1:0] a_in,
   output logic          v_out,
   output logic [AW-1:0] a_out
);
   logic [LAT-1:0] v;
   logic [AW-1:0]  a [LAT];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v <= '0;
         for (int i = 0; i < LAT; i++) a[i] <= '0;
      end else begin
         v[0] <= v_in;
         a[0] <= a_in;
         for (int i = 1; i < LAT; i++) begin
            v[i] <= v[i-1];
            a[i] <= a[i-1];
         end
      end
   assign v_out = v[LAT-1];
   assign a_out = a[LAT-1];
endmodule

// File: rtl/pe_conv_sched.sv
// pe_conv_sched: walks a KxK window row-major over a square map and schedules PE result writes
module pe_conv_sched import pe_conv_sched_pkg::*; #(
   parameter int K      = K_DEF,
   parameter int PE_LAT = PE_LAT_DEF,
   parameter int DIM_W  = 6,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  cfg_in_dim,
   input  logic              cfg_relu,
   input  logic              cfg_quan,
   input  logic [31:0]       pe_out,
   output logic              win_valid,
   output logic [DIM_W-1:0]  win_row,
   output logic [DIM_W-1:0]  win_col,
   output logic              pe_relu_en,
   output logic              pe_quan_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);
   localparam int CW = PE_LAT > 1 ? $clog2(PE_LAT) : 1;
   localparam logic [DIM_W-1:0] K_W = DIM_W'(K);
   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
   state_t state, state_d;
   logic [DIM_W-1:0]  row, col, out_dim;
   logic [ADDR_W-1:0] addr;
   logic [CW-1:0]     cnt;
   logic              relu_q, quan_q, err_q, done_q;
   logic              accept, reject, col_end, last, drain_end;
   assign accept    = state == IDLE && start && cfg_in_dim >= K_W;
   assign reject    = state == IDLE && start && cfg_in_dim < K_W;
   assign col_end   = col == out_dim - ONE;
   assign last      = col_end && row == out_dim - ONE;
   assign drain_end = cnt == CW'(PE_LAT - 1);
   always_comb begin
      state_d = state == IDLE  ? (accept ? RUN : IDLE) :
                state == RUN   ? (last ? DRAIN : RUN) :
                state == DRAIN ? (drain_end ? DONE : DRAIN) : IDLE;
   end
   // Window counters return to zero on the last window so every map starts at (0,0)
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         row     <= '0;
         col     <= '0;
         out_dim <= '0;
         addr    <= '0;
         cnt     <= '0;
         relu_q  <= 1'b0;
         quan_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state  <= state_d;
         err_q  <= reject;
         done_q <= reject || state == DONE;
         cnt    <= state == DRAIN ? cnt + CW'(1) : '0;
         if (accept) begin
            out_dim <= cfg_in_dim - K_W + ONE;
            relu_q  <= cfg_relu;
            quan_q  <= cfg_quan;
         end
         if (state == RUN) begin
            col  <= col_end ? '0 : col + ONE;
            row  <= last ? '0 : col_end ? row + ONE : row;
            addr <= last ? '0 : addr + ADDR_W'(1);
         end
      end
   assign win_valid  = state == RUN;
   assign win_row    = row;
   assign win_col    = col;
   assign busy       = state == RUN || state == DRAIN;
   assign pe_relu_en = busy && relu_q;
   assign pe_quan_en = busy && quan_q;
   assign done       = done_q;
   assign cfg_err    = err_q;
   assign wr_data    = pe_out;
   pe_lat_pipe #(.LAT(PE_LAT), .AW(ADDR_W)) u_pipe (
      .clk   (clk),
      .rst   (rst),
      .v_in  (win_valid),
      .a_in  (addr),
      .v_out (wr_en),
      .a_out (wr_addr)
   );
endmodule

// File: tb/tb_pe_conv_sched.sv
// tb_pe_conv_sched: directed map runs with randomized side inputs, checked against window-index arithmetic
module tb_pe_conv_sched;
   localparam int K = 5, L = 2, DW = 6, AW = 10;
   logic clk = 1'b0, rst, start, cfg_relu, cfg_quan;
   logic [DW-1:0] cfg_in_dim;
   logic [31:0] pe_out;
   logic win_valid, pe_relu_en, pe_quan_en, wr_en, busy, done, cfg_err;
   logic [DW-1:0] win_row, win_col;
   logic [AW-1:0] wr_addr;
   logic [31:0] wr_data;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   pe_conv_sched #(.K(K), .PE_LAT(L), .DIM_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_in_dim(cfg_in_dim), .cfg_relu(cfg_relu),
      .cfg_quan(cfg_quan), .pe_out(pe_out), .win_valid(win_valid), .win_row(win_row),
      .win_col(win_col), .pe_relu_en(pe_relu_en), .pe_quan_en(pe_quan_en), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .cfg_err(cfg_err)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
      pe_out = $urandom;
      #1;
   endtask
   task automatic chk_all(input bit v, input int r, input int c, input bit we, input int wa,
                          input bit b, input bit d, input bit e, input bit re, input bit qe);
      chk("win_valid", win_valid, v);
      if (v) begin
         chk("win_row", win_row, r);
         chk("win_col", win_col, c);
      end
      chk("wr_en", wr_en, we);
      if (we) chk("wr_addr", wr_addr, wa);
      chk("wr_data", wr_data, pe_out);
      chk("busy", busy, b);
      chk("done", done, d);
      chk("cfg_err", cfg_err, e);
      chk("pe_relu_en", pe_relu_en, re);
      chk("pe_quan_en", pe_quan_en, qe);
   endtask
   // Cycle n=1 is the first window; windows 1..w, writes L cycles later, done one cycle after DONE state
   task automatic run_map(input int dim, input bit relu, input bit quan, input int abort, input bit hold);
      int od, w;
      bit v, we, b;
      od = dim - K + 1;
      w = od * od;
      start = 1'b1;
      cfg_in_dim = DW'(dim);
      cfg_relu = relu;
      cfg_quan = quan;
      for (int n = 1; n <= w + L + 2; n++) begin
         cyc();
         v = n <= w;
         we = n > L && n <= w + L;
         b = n <= w + L;
         chk_all(v, (n - 1) / od, (n - 1) % od, we, n - 1 - L, b, n == w + L + 2, 1'b0, b && relu, b && quan);
         if (n == abort) begin
            rst = 1'b1;
            #1;
            chk_all(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst_win_row", win_row, 0);
            chk("rst_win_col", win_col, 0);
            chk("rst_wr_addr", wr_addr, 0);
            start = 1'b0;
            cyc();
            rst = 1'b0;
            return;
         end
         if (n <= w + L) begin
            start = 1'($urandom_range(0, 1));
            cfg_in_dim = DW'($urandom);
            cfg_relu = 1'($urandom);
            cfg_quan = 1'($urandom);
         end else begin
            start = hold;
            cfg_in_dim = DW'(dim);
            cfg_relu = relu;
            cfg_quan = quan;
         end
      end
      if (!hold) begin
         cyc();
         chk_all(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask
   initial begin
      rst = 1'b1;
      start = 1'b0;
      cfg_in_dim = '0;
      cfg_relu = 1'b0;
      cfg_quan = 1'b0;
      pe_out = 32'h0;
      #1;
      chk_all(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk_all(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_map(5, 1'b1, 1'b0, 0, 1'b0);
      start = 1'b1;
      cfg_in_dim = 6'd4;
      cyc();
      start = 1'b0;
      chk_all(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk_all(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      run_map(32, 1'b0, 1'b1, 0, 1'b0);
      for (int i = 0; i < 3; i++)
         run_map($urandom_range(5, 12), 1'($urandom), 1'($urandom), 0, 1'b0);
      run_map(28, 1'b1, 1'b1, 101, 1'b0);
      cyc();
      chk_all(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_map(28, 1'b1, 1'b1, 0, 1'b0);
      run_map(8, 1'b1, 1'b0, 0, 1'b1);
      run_map(8, 1'b1, 1'b0, 0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
